// File: rtl/ssemi_fir_coeff_ctrl_pkg.sv
// Shared types for the FIR coefficient-load controller.
// SSEMI_FIR_COEFF_SYM_EN selects symmetric (mirrored) tap writes.
package ssemi_fir_ctrl_pkg;

    localparam int unsigned NUM_TAPS_DEF = 64;
    localparam int unsigned COEFF_W_DEF  = 18;
    localparam int unsigned TIMEOUT_DEF  = 1024;
    localparam int unsigned TAP_IDX_W    = $clog2(NUM_TAPS_DEF);

    typedef logic [TAP_IDX_W-1:0]          tap_idx_t;
    typedef logic signed [COEFF_W_DEF-1:0] coeff_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STROBE = 3'd3,
        ST_DONE   = 3'd4
    } ssemi_fir_ctrl_state_e;

    function automatic int sym_half(input int n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/ssemi_fir_coeff_ctrl_if.sv
// Host-side tap-write / commit bundle of the coefficient controller.
// Unaffected by SSEMI_FIR_COEFF_SYM_EN.
interface ssemi_fir_coeff_ctrl_if #(
    parameter int NUM_TAPS    = 64,
    parameter int COEFF_WIDTH = 18
);
    localparam int AW = $clog2(NUM_TAPS);

    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [COEFF_WIDTH-1:0] wr_data;
    logic                   commit;
    logic                   cmd_ready;

    modport master (
        output wr_en, wr_addr, wr_data, commit,
        input  cmd_ready
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit,
        output cmd_ready
    );

endinterface

// File: rtl/ssemi_fir_coeff_bank.sv
// Shadow/active coefficient banks with written-mask and write decode.
// SSEMI_FIR_COEFF_SYM_EN: a write to tap k also fills tap NUM_TAPS-1-k.
module ssemi_fir_coeff_bank
    import ssemi_fir_ctrl_pkg::*;
#(
    parameter int NUM_TAPS    = 64,
    parameter int COEFF_WIDTH = 18
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0]         wr_addr,
    input  logic [COEFF_WIDTH-1:0]              wr_data,
    input  logic                                copy,
    input  logic                                mask_clr,
    output logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] active,
    output logic                                mask_full
);

    logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] shadow;
    logic [NUM_TAPS-1:0]                  mask;
    logic [NUM_TAPS-1:0]                  hit;

`ifdef SSEMI_FIR_COEFF_SYM_EN
    localparam int HALF = sym_half(NUM_TAPS);

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            hit[i] = wr_en && (int'(wr_addr) < HALF) &&
                     ((int'(wr_addr) == i) ||
                      (int'(wr_addr) == NUM_TAPS - 1 - i));
        end
    end
`else
    // Out-of-range addresses match no tap and fall through silently.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            hit[i] = wr_en && (int'(wr_addr) == i);
        end
    end
`endif

    // Full flag already includes a write landing in the same cycle.
    assign mask_full = &(mask | hit);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow <= '0;
            active <= '0;
            mask   <= '0;
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (hit[i]) shadow[i] <= wr_data;
            end
            if (mask_clr) mask <= '0;
            else          mask <= mask | hit;
            if (copy) active <= shadow;
        end
    end

endmodule

// File: rtl/ssemi_fir_coeff_ctrl.sv
// FIR coefficient-load controller: commit FSM, drain timeout, status.
// SSEMI_FIR_COEFF_SYM_EN (bank decode) enables symmetric tap loading.
module ssemi_fir_coeff_ctrl
    import ssemi_fir_ctrl_pkg::*;
#(
    parameter int NUM_TAPS       = 64,
    parameter int COEFF_WIDTH    = 18,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_enable,
    ssemi_fir_coeff_ctrl_if.slave                host,
    input  logic                                 i_fir_busy,
    input  logic                                 i_fir_coeff_ready,
    output logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] o_coeff,
    output logic                                 o_coeff_valid,
    output logic                                 o_hold,
    output logic                                 o_commit_done,
    output logic                                 o_loaded,
    output logic                                 o_err_incomplete,
    output logic                                 o_err_timeout,
    output logic [2:0]                           o_state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    ssemi_fir_ctrl_state_e state, state_nx;

    logic [CW-1:0] cnt;
    logic          wr_ok;
    logic          commit_req;
    logic          mask_full;
    logic          can_commit;
    logic          bank_ld;
    logic          drained;
    logic          copy;
    logic          hold_d;
    logic          valid_d;
    logic          done_d;

    assign wr_ok      = host.wr_en && (state == ST_IDLE);
    assign commit_req = host.commit && i_enable && (state == ST_IDLE);
    // After a disable the retained active bank may be reloaded as-is.
    assign can_commit = mask_full || (!o_loaded && bank_ld);
    assign drained    = !i_fir_busy && i_fir_coeff_ready;
    assign copy       = (state == ST_LOAD) && i_enable;

    assign host.cmd_ready = (state == ST_IDLE);
    assign o_state        = state;

    ssemi_fir_coeff_bank #(
        .NUM_TAPS    (NUM_TAPS),
        .COEFF_WIDTH (COEFF_WIDTH)
    ) u_bank (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .wr_en     (wr_ok),
        .wr_addr   (host.wr_addr),
        .wr_data   (host.wr_data),
        .copy      (copy),
        .mask_clr  (done_d),
        .active    (o_coeff),
        .mask_full (mask_full)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (commit_req && can_commit) state_nx = ST_DRAIN;
            ST_DRAIN: begin
                if (drained)              state_nx = ST_LOAD;
                else if (cnt == CNT_LAST) state_nx = ST_IDLE;
            end
            ST_LOAD:   state_nx = ST_STROBE;
            ST_STROBE: state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
        if (!i_enable) state_nx = ST_IDLE;
    end

    // Decoded from the next state so the flopped outputs align with it.
    always_comb begin
        hold_d  = state_nx inside {ST_DRAIN, ST_LOAD, ST_STROBE, ST_DONE};
        valid_d = (state_nx == ST_STROBE);
        done_d  = (state_nx == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            o_hold        <= 1'b0;
            o_coeff_valid <= 1'b0;
            o_commit_done <= 1'b0;
        end else begin
            state         <= state_nx;
            o_hold        <= hold_d;
            o_coeff_valid <= valid_d;
            o_commit_done <= done_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (state == ST_DRAIN) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_loaded         <= 1'b0;
            o_err_incomplete <= 1'b0;
            o_err_timeout    <= 1'b0;
            bank_ld          <= 1'b0;
        end else begin
            if (done_d) begin
                o_loaded         <= 1'b1;
                o_err_incomplete <= 1'b0;
                o_err_timeout    <= 1'b0;
            end else begin
                if (commit_req && !can_commit) o_err_incomplete <= 1'b1;
                if (state == ST_DRAIN && state_nx == ST_IDLE && i_enable)
                    o_err_timeout <= 1'b1;
                if (!i_enable) o_loaded <= 1'b0;
            end
            if (copy) bank_ld <= 1'b1;
        end
    end

endmodule
